shift_sequencer: RTL

//  Multi-cycle controller for the 2-bit barrel shifter on the Y path: performs a

---
 rtl/shift_sequencer_if.sv | 24 ++
 rtl/shift_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Control-side handshake between the control unit and shift_sequencer.
// master = control unit, slave = sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic             dir;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, dir, amount, data_in,
        input  busy, done, result
    );

    modport slave (
        input  start, dir, amount, data_in,
        output busy, done, result
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 0..15-bit shift built from repeated passes through a 2-bit barrel shifter.
// Optional SHIFT_SEQ_EARLY_EXIT_EN: finish as soon as the value can no longer change.
module shift_sequencer #(
    parameter int WIDTH    = 16,
    parameter int AMT_W    = 4,
    parameter int STEP_MAX = 3
) (
    input  logic               clk,
    input  logic               reset,
    shift_sequencer_if.slave   ctrl,
    output logic [WIDTH-1:0]   sh_from_Y,
    input  logic [WIDTH-1:0]   sh_Y_shifted,
    output logic               sh_left,
    output logic               sh_right,
    output logic [1:0]         sh_amt
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [AMT_W-1:0] STEP_MAX_W = AMT_W'(STEP_MAX);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sh_left_q, sh_left_d;
    logic             sh_right_q, sh_right_d;
    logic [1:0]       sh_amt_q, sh_amt_d;

    logic [AMT_W-1:0] step_now;
    logic [AMT_W-1:0] post_rem;
    logic [AMT_W-1:0] next_step;
    logic [AMT_W-1:0] first_step;
    logic             value_fixed;

    assign step_now   = (rem_q > STEP_MAX_W) ? STEP_MAX_W : rem_q;
    assign post_rem   = rem_q - step_now;
    assign next_step  = (post_rem > STEP_MAX_W) ? STEP_MAX_W : post_rem;
    assign first_step = (ctrl.amount > STEP_MAX_W) ? STEP_MAX_W : ctrl.amount;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    // Left: zero stays zero. Right: all-sign-bit value is a fixed point of >>>.
    assign value_fixed = dir_q ? (sh_Y_shifted == {WIDTH{sh_Y_shifted[WIDTH-1]}})
                               : (sh_Y_shifted == '0);
`else
    assign value_fixed = 1'b0;
`endif

    // Shifter controls are registered one cycle ahead so they line up with SHIFT.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        result_d   = result_q;
        rem_d      = rem_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        sh_left_d  = 1'b0;
        sh_right_d = 1'b0;
        sh_amt_d   = 2'd0;
        case (state_q)
            IDLE: begin
                if (ctrl.start) begin
                    acc_d = ctrl.data_in;
                    rem_d = ctrl.amount;
                    dir_d = ctrl.dir;
                    if (ctrl.amount == '0) begin
                        state_d  = DONE;
                        result_d = ctrl.data_in;
                        done_d   = 1'b1;
                    end else begin
                        state_d    = SHIFT;
                        sh_left_d  = ~ctrl.dir;
                        sh_right_d = ctrl.dir;
                        sh_amt_d   = 2'(first_step);
                    end
                end
            end
            SHIFT: begin
                acc_d = sh_Y_shifted;
                rem_d = post_rem;
                if (post_rem == '0 || value_fixed) begin
                    state_d  = DONE;
                    rem_d    = '0;
                    result_d = sh_Y_shifted;
                    done_d   = 1'b1;
                end else begin
                    sh_left_d  = ~dir_q;
                    sh_right_d = dir_q;
                    sh_amt_d   = 2'(next_step);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            result_q   <= '0;
            rem_q      <= '0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sh_left_q  <= 1'b0;
            sh_right_q <= 1'b0;
            sh_amt_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            rem_q      <= rem_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sh_left_q  <= sh_left_d;
            sh_right_q <= sh_right_d;
            sh_amt_q   <= sh_amt_d;
        end
    end

    assign ctrl.busy   = busy_q;
    assign ctrl.done   = done_q;
    assign ctrl.result = result_q;
    assign sh_from_Y   = acc_q;
    assign sh_left     = sh_left_q;
    assign sh_right    = sh_right_q;
    assign sh_amt      = sh_amt_q;
endmodule
